// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the keypad code-lock controller.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    typedef logic [3:0] digit_t;

    function automatic int cnt_width(input int digits);
        return $clog2(digits + 1);
    endfunction

    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/code_lock_timer.sv
// Loadable down-counter; done is high for the single cycle the count sits at zero.
module code_lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;
    logic             run;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code-lock supervisor: digit entry, code check, auto-relock and failure lockout.
// Optional code programming while open is compiled in with CODE_LOCK_PROG_EN.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int          DIGITS       = 4,
    parameter logic [31:0] DEFAULT_CODE = 32'h0000_2327,
    parameter int          MAX_FAIL     = 3,
    parameter int          OPEN_CYC     = 500,
    parameter int          LOCKOUT_CYC  = 1000
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  digit_t i_code,
    input  logic   i_code_vld,
    input  logic   i_enter,
    input  logic   i_close,
    input  logic   i_prog,
    output logic   o_open,
    output logic   o_fail,
    output logic   o_locked,
    output logic [3:0] o_fail_cnt,
    output logic   o_prog_ack
);

    localparam int ENTRY_W = DIGITS * 4;
    localparam int CNT_W   = cnt_width(DIGITS);
    localparam int TMR_W   = tmr_width(OPEN_CYC, LOCKOUT_CYC);

    localparam logic [CNT_W-1:0]   FULL       = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0]   OPEN_LOAD  = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]   LOCK_LOAD  = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [3:0]         FAIL_LIMIT = 4'(MAX_FAIL);
    localparam logic [ENTRY_W-1:0] RESET_CODE = DEFAULT_CODE[ENTRY_W-1:0];

    state_t             state, state_nxt;
    logic [ENTRY_W-1:0] entry, entry_shift, code;
    logic [CNT_W-1:0]   count, count_inc;
    logic [3:0]         fail_cnt, fail_next;
    logic               fail_q, match, leave_open;
    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_val;

    // Newest digit lands in the low nibble; the oldest falls off the top.
    assign entry_shift = ENTRY_W'({entry, i_code});
    assign count_inc   = (count == FULL) ? count : count + 1'b1;
    assign match       = (count == FULL) && (entry == code);
    assign fail_next   = fail_cnt + 4'd1;
    assign leave_open  = i_close || tmr_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        o_open    = 1'b0;
        o_locked  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = OPEN_LOAD;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (i_enter)         state_nxt = ST_CHECK;
                else if (i_code_vld) state_nxt = ST_ENTRY;
            end
            ST_CHECK: begin
                tmr_load = 1'b1;
                if (match) begin
                    state_nxt = ST_OPEN;
                end else begin
                    tmr_val   = LOCK_LOAD;
                    state_nxt = (fail_next == FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN: begin
                o_open = 1'b1;
                if (leave_open) state_nxt = ST_IDLE;
            end
            ST_LOCKOUT: begin
                o_locked = 1'b1;
                if (tmr_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            entry    <= '0;
            count    <= '0;
            fail_cnt <= 4'd0;
            fail_q   <= 1'b0;
        end else begin
            fail_q <= 1'b0;
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (!i_enter && i_code_vld) begin
                        entry <= entry_shift;
                        count <= count_inc;
                    end
                end
                ST_CHECK: begin
                    entry <= '0;
                    count <= '0;
                    if (match) begin
                        fail_cnt <= 4'd0;
                    end else begin
                        fail_cnt <= fail_next;
                        fail_q   <= 1'b1;
                    end
                end
`ifdef CODE_LOCK_PROG_EN
                ST_OPEN: begin
                    if (leave_open || i_prog) begin
                        entry <= '0;
                        count <= '0;
                    end else if (i_code_vld) begin
                        entry <= entry_shift;
                        count <= count_inc;
                    end
                end
`endif
                ST_LOCKOUT: begin
                    if (tmr_done) fail_cnt <= 4'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef CODE_LOCK_PROG_EN
    logic ack_q;

    // NOTE: the code register is reset on purpose so a reset restores DEFAULT_CODE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code  <= RESET_CODE;
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (state == ST_OPEN && i_prog && count == FULL) begin
                code  <= entry;
                ack_q <= 1'b1;
            end
        end
    end

    assign o_prog_ack = ack_q;
`else
    logic unused_prog;

    assign code        = RESET_CODE;
    assign unused_prog = i_prog;
    assign o_prog_ack  = 1'b0;
`endif

    code_lock_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign o_fail     = fail_q;
    assign o_fail_cnt = fail_cnt;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with default parameters (code 2327, 3 fails, 500/1000 cycles).
// The programming sequence runs only when CODE_LOCK_PROG_EN is defined.
module tb_code_lock_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_code;
    logic       i_code_vld;
    logic       i_enter;
    logic       i_close;
    logic       i_prog;
    logic       o_open;
    logic       o_fail;
    logic       o_locked;
    logic [3:0] o_fail_cnt;
    logic       o_prog_ack;

    int checks = 0;
    int errors = 0;

    code_lock_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_code     (i_code),
        .i_code_vld (i_code_vld),
        .i_enter    (i_enter),
        .i_close    (i_close),
        .i_prog     (i_prog),
        .o_open     (o_open),
        .o_fail     (o_fail),
        .o_locked   (o_locked),
        .o_fail_cnt (o_fail_cnt),
        .o_prog_ack (o_prog_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic digit(input logic [3:0] d);
        i_code     = d;
        i_code_vld = 1'b1;
        step();
        i_code_vld = 1'b0;
    endtask

    task automatic press4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        digit(a);
        digit(b);
        digit(c);
        digit(d);
    endtask

    task automatic enter();
        i_enter = 1'b1;
        step();
        i_enter = 1'b0;
    endtask

    task automatic close_lock();
        i_close = 1'b1;
        step();
        i_close = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_code = 4'd0; i_code_vld = 1'b0;
        i_enter = 1'b0; i_close = 1'b0; i_prog = 1'b0;
        repeat (2) step();
        check("rst_open", o_open, 0);
        check("rst_fail", o_fail, 0);
        check("rst_locked", o_locked, 0);
        check("rst_fail_cnt", o_fail_cnt, 0);
        check("rst_prog_ack", o_prog_ack, 0);
        i_rst = 1'b0;
        step();

        // Correct code opens after CHECK and auto-relocks after exactly 500 cycles.
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        check("open_in_check", o_open, 0);
        step();
        check("open_rise", o_open, 1);
        check("open_fail_cnt", o_fail_cnt, 0);
        check("open_no_fail", o_fail, 0);
        repeat (499) step();
        check("open_last_cycle", o_open, 1);
        step();
        check("open_timeout", o_open, 0);

        // Manual close 10 cycles after opening.
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("open2_rise", o_open, 1);
        repeat (10) step();
        check("open2_before_close", o_open, 1);
        close_lock();
        check("close_drop", o_open, 0);
        check("close_not_locked", o_locked, 0);

        // Close while idle does nothing; the correct code still opens.
        close_lock();
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("idle_close_then_open", o_open, 1);
        close_lock();

        // Three wrong attempts lead to a 1000-cycle lockout.
        for (int k = 1; k <= 3; k++) begin
            press4(4'd1, 4'd2, 4'd3, 4'd4);
            enter();
            step();
            check("wrong_fail_pulse", o_fail, 1);
            check("wrong_fail_cnt", o_fail_cnt, k);
            check("wrong_locked", o_locked, (k == 3) ? 1 : 0);
            step();
            check("wrong_fail_single", o_fail, 0);
        end
        // Lockout cycle 2 here; correct code during lockout is ignored.
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("lockout_ignores_code", o_open, 0);
        check("lockout_still_locked", o_locked, 1);
        check("lockout_fail_cnt", o_fail_cnt, 3);
        repeat (992) step();
        check("lockout_last_cycle", o_locked, 1);
        step();
        check("lockout_end", o_locked, 0);
        check("lockout_cnt_clear", o_fail_cnt, 0);
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("post_lockout_open", o_open, 1);
        close_lock();

        // Five digits: the leading 9 drops out of the register.
        digit(4'd9);
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("five_digits_open", o_open, 1);
        close_lock();

        // Short entry is rejected.
        digit(4'd2); digit(4'd3); digit(4'd2);
        enter();
        step();
        check("short_fail", o_fail, 1);
        check("short_fail_cnt", o_fail_cnt, 1);
        check("short_not_open", o_open, 0);
        step();

        // Enter wins over a digit in the same cycle.
        digit(4'd2); digit(4'd3); digit(4'd2);
        i_code = 4'd7; i_code_vld = 1'b1; i_enter = 1'b1;
        step();
        i_code_vld = 1'b0; i_enter = 1'b0;
        step();
        check("same_cycle_fail", o_fail, 1);
        check("same_cycle_fail_cnt", o_fail_cnt, 2);
        check("same_cycle_not_open", o_open, 0);
        step();
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("match_clears_cnt", o_fail_cnt, 0);

        // Reset while open.
        i_rst = 1'b1;
        step();
        check("rst_mid_open", o_open, 0);
        i_rst = 1'b0;
        step();

        // Reset while locked out.
        for (int k = 0; k < 3; k++) begin
            press4(4'd5, 4'd5, 4'd5, 4'd5);
            enter();
            step();
        end
        check("lock_again", o_locked, 1);
        i_rst = 1'b1;
        step();
        check("rst_mid_lock", o_locked, 0);
        check("rst_mid_lock_cnt", o_fail_cnt, 0);
        check("rst_mid_lock_fail", o_fail, 0);
        i_rst = 1'b0;
        step();

`ifdef CODE_LOCK_PROG_EN
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("prog_open", o_open, 1);
        press4(4'd1, 4'd1, 4'd1, 4'd1);
        i_prog = 1'b1;
        step();
        i_prog = 1'b0;
        check("prog_ack", o_prog_ack, 1);
        check("prog_stays_open", o_open, 1);
        step();
        check("prog_ack_single", o_prog_ack, 0);
        close_lock();
        press4(4'd1, 4'd1, 4'd1, 4'd1);
        enter();
        step();
        check("new_code_opens", o_open, 1);
        close_lock();
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("old_code_fails", o_fail, 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        press4(4'd2, 4'd3, 4'd2, 4'd7);
        enter();
        step();
        check("rst_restores_code", o_open, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Supervisory controller for the keypad code lock. Collects a digit stream, compares a complete entry against a stored code on an explicit submit strobe, and drives the lock-open output with an auto-relock timeout. Counts consecutive failed attempts and enforces a timed lockout. Sits between the keypad decoder (digit strobes) and the lock actuator / status LEDs.

## Interface
- `DIGITS`, 4: code length in digits (1..8).
- `DEFAULT_CODE`, 32'h0000_2327: reset code, 4 bits per digit, first digit in the most significant used nibble.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (1..15).
- `OPEN_CYC`, 500: cycles the lock stays open without `i_close`.
- `LOCKOUT_CYC`, 1000: lockout duration in cycles.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_code`  in  4  digit value, 0..9; 10..15 are accepted as literal values.
- `i_code_vld`  in  1  one-cycle digit strobe.
- `i_enter`  in  1  submit strobe.
- `i_close`  in  1  manual relock request.
- `i_prog`  in  1  code-program strobe (see Configuration).
- `o_open`  out  1  lock open.
- `o_fail`  out  1  one-cycle pulse per rejected attempt.
- `o_locked`  out  1  lockout in progress.
- `o_fail_cnt`  out  4  consecutive failure count.
- `o_prog_ack`  out  1  one-cycle pulse, new code stored.

## Operation
- States: IDLE (no digits held), ENTRY (1..DIGITS digits held), CHECK, OPEN, LOCKOUT.
- The entry register is a DIGITS-deep nibble shift register. New digits shift in at the LSB end, and the oldest digit drops out. The entry count saturates at DIGITS.
- IDLE/ENTRY + `i_code_vld` → shift digit, count+1, state ENTRY.
- IDLE/ENTRY + `i_enter` → CHECK. `i_enter` has priority: a digit strobed in the same cycle is discarded.
- CHECK, one cycle:
  - Match requires count==DIGITS and entry==code. On match: OPEN, fail count cleared.
  - Otherwise: `o_fail` pulse and fail count +1. If the new count equals MAX_FAIL, go to LOCKOUT; else go to IDLE.
  - The entry register and count are cleared on every CHECK exit.
- OPEN: leave to IDLE on `i_close`, or when the open timer reaches OPEN_CYC cycles, whichever comes first. `i_enter` and `i_code_vld` are ignored unless PROG is compiled in.
- LOCKOUT: all inputs are ignored. After LOCKOUT_CYC cycles, go to IDLE and clear the fail count.
- `i_close` outside OPEN has no effect.
- Fail count only clears on a match, on lockout expiry, or on reset.

## Timing
- Reset values: state IDLE, entry/count 0, code=DEFAULT_CODE, `o_open`=0, `o_fail`=0, `o_locked`=0, `o_fail_cnt`=0, `o_prog_ack`=0.
- All outputs are registered or decoded directly from registered state, with no combinational input-to-output paths.
- `i_enter` sampled at edge N → CHECK after N → result after edge N+1:
  - on match, `o_open` rises after edge N+1;
  - on mismatch, `o_fail` is high for the single cycle after edge N+1.
- With no close, `o_open` stays high for exactly OPEN_CYC cycles.
- `i_close` sampled at edge M → `o_open` low after M.
- `o_locked` is high for exactly LOCKOUT_CYC cycles. It rises together with the final `o_fail` pulse.
- `o_fail_cnt` updates in the same cycle as `o_fail`.
- `i_rst` mid-OPEN or mid-LOCKOUT: everything returns to reset values on the next edge, and the code reverts to DEFAULT_CODE.

## Configuration
- Macro: `CODE_LOCK_PROG_EN`.
- Defined (PROG compiled in):
  - In OPEN, `i_code_vld` shifts digits into the entry register.
  - `i_prog` with count==DIGITS copies the entry into the code register. The entry is then cleared, `o_prog_ack` pulses for one cycle, and the block stays OPEN.
  - `i_prog` with count<DIGITS clears the entry only.
  - Leaving OPEN clears the entry.
- Undefined:
  - The code is the constant DEFAULT_CODE.
  - `i_prog` is ignored and `o_prog_ack` is tied 0.
  - Digits in OPEN are ignored.

## Structure
- Package `code_lock_pkg`: state enum (`logic [2:0]`), `digit_t` (`logic [3:0]`), and digit-count width function.
- Sub-module `code_lock_timer`: loadable down-counter with a one-cycle `done` output.
  - It is shared between OPEN and LOCKOUT and loaded on each state entry.
  - Its width is derived from max(OPEN_CYC, LOCKOUT_CYC).

## Test plan
- Enter digits 2,3,2,7 then `i_enter` → `o_open` high 2 cycles after the enter edge; `o_fail_cnt`=0; with no close, `o_open` stays high for 500 cycles.
- Enter 2,3,2,7, then `i_enter`, then `i_close` 10 cycles later → `o_open` low the next cycle; state IDLE.
- Enter 1,2,3,4, then `i_enter`, three times → `o_fail` pulses ×3, `o_fail_cnt` 1,2,3. `o_locked` is high for 1000 cycles and the correct code is ignored meanwhile. Afterwards the count is 0 and 2,3,2,7 opens the lock.
- Enter 9,2,3,2,7 (five digits, the oldest drops), then `i_enter` → opens. Enter 2,3,2, then `i_enter` → `o_fail` pulse.
- `i_enter` and `i_code_vld` in the same cycle with a count of 3 → the digit is dropped and the attempt fails.
- With `CODE_LOCK_PROG_EN`: open, enter 1,1,1,1, then `i_prog` → `o_prog_ack` pulse. After close, 1,1,1,1 opens the lock and 2,3,2,7 fails. After `i_rst`, 2,3,2,7 opens again.
